// File: rtl/bp_pkg.sv
// ============================================================================
// Module      : bp_pkg
// Description : Shared branch-prediction types and constants.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package bp_pkg;

    localparam int HIST_BITS   = 10;
    localparam int PHT_ENTRIES = 1 << HIST_BITS;

    typedef logic [HIST_BITS-1:0] pht_idx_t;
    typedef logic [1:0]           sat2_t;

    // Bit [1] of the counter is the prediction
    localparam sat2_t SNT = 2'b00;
    localparam sat2_t WNT = 2'b01;
    localparam sat2_t WT  = 2'b10;
    localparam sat2_t ST  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/sat_counter2.sv
// ============================================================================
// Module      : sat_counter2
// Description : Two-bit saturating counter next-state logic (combinational).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter2
    import bp_pkg::*;
(
    input  sat2_t i_cur,
    input  logic  i_taken,
    output sat2_t o_next
);

    always_comb begin
        o_next = i_cur;
        if (i_taken) begin
            if (i_cur != ST) begin
                o_next = i_cur + 2'd1;
            end
        end else if (i_cur != SNT) begin
            o_next = i_cur - 2'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gshare_pht.sv
// ============================================================================
// Module      : gshare_pht
// Description : Gshare pattern history table; predicts in Fetch, trains in Execute.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module gshare_pht
    import bp_pkg::sat2_t;
    import bp_pkg::WNT;
#(
    parameter int    HIST_BITS = bp_pkg::HIST_BITS,
    parameter int    PC_LSB    = 2,
    parameter sat2_t CNT_INIT  = WNT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          PCF,
    input  logic [HIST_BITS-1:0] gbh_reg,
    input  logic                 StallD,
    input  logic                 FlushD,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 BranchE,
    input  logic                 br_actualE,
    output logic                 predict_takenF,
    output logic                 predict_takenE,
    output logic                 mispredictE
);

    localparam int ENTRIES = 1 << HIST_BITS;

    sat2_t                pht_q [0:ENTRIES-1];
    sat2_t                pht_d [0:ENTRIES-1];
    logic [HIST_BITS-1:0] idx_f;
    logic [HIST_BITS-1:0] idx_dec_q, idx_dec_d;
    logic                 pred_dec_q, pred_dec_d;
    logic [HIST_BITS-1:0] idx_ex_q, idx_ex_d;
    logic                 pred_ex_q, pred_ex_d;
    sat2_t                cnt_next;
    logic                 unused_pcf;

    // Only the index slice of the PC matters; the rest is folded away here
    assign unused_pcf = ^PCF;

    assign idx_f          = PCF[PC_LSB+HIST_BITS-1:PC_LSB] ^ gbh_reg;
    assign predict_takenF = pht_q[idx_f][1];
    assign predict_takenE = pred_ex_q;
    assign mispredictE    = BranchE & (pred_ex_q != br_actualE);

    sat_counter2 u_sat (
        .i_cur   (pht_q[idx_ex_q]),
        .i_taken (br_actualE),
        .o_next  (cnt_next)
    );

    always_comb begin
        pht_d = pht_q;
        if (BranchE) begin
            pht_d[idx_ex_q] = cnt_next;
        end
    end

    always_comb begin
        idx_dec_d  = idx_dec_q;
        pred_dec_d = pred_dec_q;
        idx_ex_d   = idx_ex_q;
        pred_ex_d  = pred_ex_q;
        if (FlushD) begin
            idx_dec_d  = '0;
            pred_dec_d = 1'b0;
        end else if (!StallD) begin
            idx_dec_d  = idx_f;
            pred_dec_d = predict_takenF;
        end
        if (FlushE) begin
            idx_ex_d  = '0;
            pred_ex_d = 1'b0;
        end else if (!StallE) begin
            idx_ex_d  = idx_dec_q;
            pred_ex_d = pred_dec_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_dec_q  <= '0;
            pred_dec_q <= 1'b0;
            idx_ex_q   <= '0;
            pred_ex_q  <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) begin
                pht_q[i] <= CNT_INIT;
            end
        end else begin
            idx_dec_q  <= idx_dec_d;
            pred_dec_q <= pred_dec_d;
            idx_ex_q   <= idx_ex_d;
            pred_ex_q  <= pred_ex_d;
            pht_q      <= pht_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gshare_pht.sv
// ============================================================================
// Module      : tb_gshare_pht
// Description : Directed self-checking bench for gshare_pht.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gshare_pht;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCF;
    logic [9:0]  gbh_reg;
    logic        StallD, FlushD, StallE, FlushE;
    logic        BranchE, br_actualE;
    logic        predict_takenF, predict_takenE, mispredictE;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gshare_pht dut (
        .clk            (clk),
        .reset          (reset),
        .PCF            (PCF),
        .gbh_reg        (gbh_reg),
        .StallD         (StallD),
        .FlushD         (FlushD),
        .StallE         (StallE),
        .FlushE         (FlushE),
        .BranchE        (BranchE),
        .br_actualE     (br_actualE),
        .predict_takenF (predict_takenF),
        .predict_takenE (predict_takenE),
        .mispredictE    (mispredictE)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_to_exec(input logic [31:0] pc, input logic [9:0] gbh);
        PCF     = pc;
        gbh_reg = gbh;
        tick();
        tick();
    endtask

    task automatic train(input logic taken);
        BranchE    = 1'b1;
        br_actualE = taken;
        tick();
        BranchE    = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1; PCF = 32'h0; gbh_reg = '0;
        StallD = 0; FlushD = 0; StallE = 0; FlushE = 0;
        BranchE = 0; br_actualE = 0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        PCF = 32'h0000_0040; gbh_reg = '0; #1;
        check("rst_predF", {31'd0, predict_takenF}, 32'd0);
        check("rst_predE", {31'd0, predict_takenE}, 32'd0);
        check("rst_misp", {31'd0, mispredictE}, 32'd0);
        check("rst_pht3ff", {30'd0, dut.pht_q[10'h3ff]}, 32'd1);
        check("rst_pht010", {30'd0, dut.pht_q[10'h010]}, 32'd1);

        // First taken branch at idx 0x040
        fetch_to_exec(32'h100, 10'h000);
        BranchE = 1'b1; br_actualE = 1'b1; #1;
        check("first_misp", {31'd0, mispredictE}, 32'd1);
        tick();
        BranchE = 1'b0; #1;
        check("first_pht", {30'd0, dut.pht_q[10'h040]}, 32'h2);
        check("first_predF", {31'd0, predict_takenF}, 32'd1);

        // Saturate up, then one not-taken
        repeat (4) train(1'b1);
        check("sat_hi", {30'd0, dut.pht_q[10'h040]}, 32'h3);
        BranchE = 1'b1; br_actualE = 1'b0; #1;
        check("nt_misp", {31'd0, mispredictE}, 32'd1);
        tick();
        BranchE = 1'b0; #1;
        check("nt_pht", {30'd0, dut.pht_q[10'h040]}, 32'h2);
        check("nt_predF", {31'd0, predict_takenF}, 32'd1);

        // XOR aliasing: 0x100 ^ gbh 0x040 -> idx 0
        fetch_to_exec(32'h100, 10'h040);
        train(1'b1);
        check("alias_pht0", {30'd0, dut.pht_q[10'h000]}, 32'h2);
        check("alias_pht40", {30'd0, dut.pht_q[10'h040]}, 32'h2);

        // StallD holds the original instruction
        PCF = 32'h100; gbh_reg = '0;
        tick();
        StallD = 1'b1; PCF = 32'h400;
        tick();
        PCF = 32'h404;
        tick();
        check("stall_idxE", {22'd0, dut.idx_ex_q}, 32'h040);
        check("stall_predE", {31'd0, predict_takenE}, 32'd1);
        StallD = 1'b0; PCF = 32'h400;
        tick();
        tick();
        check("unstall_predE", {31'd0, predict_takenE}, 32'd0);

        // FlushE beats StallE
        PCF = 32'h100;
        tick();
        tick();
        check("preflush_predE", {31'd0, predict_takenE}, 32'd1);
        FlushE = 1'b1; StallE = 1'b1;
        tick();
        FlushE = 1'b0; StallE = 1'b0; br_actualE = 1'b1; #1;
        check("flush_predE", {31'd0, predict_takenE}, 32'd0);
        check("flush_idxE", {22'd0, dut.idx_ex_q}, 32'h0);
        check("nobr_misp", {31'd0, mispredictE}, 32'd0);

        // Same-cycle train and read of idx 0x123: read-old
        fetch_to_exec(32'h48C, 10'h000);
        BranchE = 1'b1; br_actualE = 1'b1; #1;
        check("rw_predF_old", {31'd0, predict_takenF}, 32'd0);
        tick();
        BranchE = 1'b0; #1;
        check("rw_predF_new", {31'd0, predict_takenF}, 32'd1);
        check("rw_pht", {30'd0, dut.pht_q[10'h123]}, 32'h2);

        // Saturate down at 00
        repeat (3) train(1'b0);
        check("sat_lo", {30'd0, dut.pht_q[10'h123]}, 32'h0);
        check("sat_lo_predF", {31'd0, predict_takenF}, 32'd0);

        // Reset discards a same-cycle training update
        fetch_to_exec(32'h100, 10'h000);
        BranchE = 1'b1; br_actualE = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; br_actualE = 1'b0; #1;
        check("rstmid_pht", {30'd0, dut.pht_q[10'h040]}, 32'h1);
        check("rstmid_predE", {31'd0, predict_takenE}, 32'd0);
        check("rstmid_misp", {31'd0, mispredictE}, 32'd0);
        BranchE = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/gshare_pht.md
Name: gshare_pht

Overview:
- Gshare pattern history table that consumes the 10-bit global branch history register.
- In Fetch it indexes 1024 two-bit saturating counters with PCF[11:2] XOR the history, and produces a taken prediction.
- The index and prediction are carried down the pipeline to Execute. There the resolved outcome trains the same counter and a mispredict flag is raised.
- It sits beside the history register in the branch-prediction path, between Fetch and Execute.

Parameters:
- HIST_BITS, 10, history width; also index width. The table has 2^HIST_BITS entries.
- PC_LSB, 2, lowest PC bit used in the index (word-aligned instructions).
- CNT_INIT, 2'b01, counter value after reset (weakly not-taken).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- PCF  in  32  Fetch-stage PC
- gbh_reg  in  HIST_BITS  current global history value
- StallD  in  1  hold the F/D pipeline register
- FlushD  in  1  clear the F/D pipeline register
- StallE  in  1  hold the D/E pipeline register
- FlushE  in  1  clear the D/E pipeline register
- BranchE  in  1  a conditional branch is resolving in Execute
- br_actualE  in  1  resolved outcome (1 = taken)
- predict_takenF  out  1  Fetch prediction, combinational
- predict_takenE  out  1  prediction carried with the instruction now in Execute
- mispredictE  out  1  BranchE & (predict_takenE != br_actualE)

Behaviour:
- Clock and reset: clk, with reset synchronous and active-high. All state updates on the rising edge of clk.
- Index in Fetch: idxF = PCF[PC_LSB+HIST_BITS-1:PC_LSB] ^ gbh_reg. Combinational.
- Prediction: predict_takenF = pht[idxF][1]. Asynchronous read, zero-cycle latency from PCF/gbh_reg.
- Pipeline registers: {idxD, predD} latch from Fetch and {idxE, predE} latch from Decode.
- Pipeline register priority: reset > flush > stall > load.
  - Flush clears that register to idx=0, pred=0.
  - Stall holds the current value.
- predict_takenE = predE.
- Training: on the clock edge with BranchE=1, update pht[idxE].
  - Taken: increment, saturating at 2'b11.
  - Not taken: decrement, saturating at 2'b00.
  - With BranchE=0 the table is unchanged.
- Training ignores StallE. Upstream hazard logic must not assert BranchE twice for one branch.
- Same-cycle read and write of one index: the Fetch read returns the pre-update value (read-old). There is no bypass.
- History interaction: the history register shifts on the same edge as training. The index is computed against the pre-shift history, so the Fetch index uses the history before the resolving branch's shift.
- Reset:
  - All counters become CNT_INIT.
  - idxD, predD, idxE and predE become 0.
  - Hence predict_takenE=0 and mispredictE=0 immediately. predict_takenF=0 for every index after reset.
- Reset mid-operation: a pending training update in the same cycle is discarded; reset wins.
- Counter states: 00 strongly-NT, 01 weakly-NT, 10 weakly-T, 11 strongly-T. The prediction is bit [1].
- mispredictE is combinational and is 0 whenever BranchE=0.

Decomposition:
- Shared package bp_pkg:
  - HIST_BITS and PHT_ENTRIES constants.
  - typedef pht_idx_t = logic [HIST_BITS-1:0].
  - typedef sat2_t = logic [1:0], with named constants SNT/WNT/WT/ST.
- One natural sub-module: sat_counter2. This is combinational next-state logic (cur, taken -> next) with saturation, reused by any future bimodal/tournament predictor.
- The table array and pipeline registers stay in gshare_pht.

Test Plan:
- Reset, then PCF=0x0000_0040, gbh_reg=0 -> predict_takenF=0 and predict_takenE=0; an internal probe of any counter reads 2'b01.
- Branch at PCF=0x100, gbh=0 (idx 0x040), pipelined to Execute with BranchE=1, br_actualE=1 -> mispredictE=1 that cycle and pht[0x040]=2'b10; the next fetch of idx 0x040 gives predict_takenF=1.
- Four taken trainings on idx 0x040 -> counter saturates at 2'b11. Then one not-taken -> 2'b10, and prediction is still taken.
- Aliasing/XOR: PCF=0x100 with gbh=0x040 -> idx 0x000. Training that index leaves pht[0x040] unchanged.
- StallD=1 for 2 cycles while PCF changes -> idxE/predE reflect the original instruction. FlushE=1 -> predict_takenE=0 next cycle, and FlushE wins when StallE=1 simultaneously.
- Same cycle: BranchE trains idx 0x123 from 01 to 10 while Fetch reads idx 0x123 -> predict_takenF=0 that cycle and 1 the following cycle.
